// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter.
//   DATA_W       operand / result width
//   OP_*         requester and ALU opcodes (OP_PASS drives result = B)
//   state_e      controller FSM encoding
//   rsp_kind_e   how the response of an accepted operation is formed
//   classify_op  decides, at acceptance, whether an operation reaches the ALU
package alu_ctrl_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RSP_ALU     = 2'd0,  // data = alu_result, no error
        RSP_ALU_ERR = 2'd1,  // data = alu_result, error (multiply operand > 8 bits)
        RSP_DIV0    = 2'd2,  // no issue, data = all ones, error
        RSP_ILLEGAL = 2'd3   // no issue, data = 0, error
    } rsp_kind_e;

    function automatic rsp_kind_e classify_op(input logic [2:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        rsp_kind_e kind;
        case (op)
            OP_ADD, OP_SUB: kind = RSP_ALU;
            OP_MUL: kind = ((|a[DATA_W-1:DATA_W/2]) || (|b[DATA_W-1:DATA_W/2]))
                           ? RSP_ALU_ERR : RSP_ALU;
            OP_DIV: kind = (b == '0) ? RSP_DIV0 : RSP_ALU;
            default: kind = RSP_ILLEGAL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way arbiter with round-robin or fixed (port 0 first) priority.
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     request vector
//   fixed        1: port 0 always wins a tie; 0: port not granted last wins
//   update       record the current grant as the last grant
//   gnt[1:0]     one-hot grant (combinational)
//   last_grant   index of the most recently granted port; resets to 1
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       fixed,
    input  logic       update,
    output logic [1:0] gnt,
    output logic       last_grant
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (fixed || last_grant_q) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase

        last_grant_d = last_grant_q;
        if (update && (|gnt)) begin
            last_grant_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters sharing one registered ALU.
//   clk, rst_n                        clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b           request handshake and fields (N = 0,1)
//   rspN_valid/data/err               one-cycle response pulse, held data/err
//   alu_a/alu_b/alu_op                registered operands to the shared ALU
//   alu_result                        registered ALU output, ALU_LAT edges behind
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready offered to the arbitration winner, alu_op = PASS
//   ST_EXEC | one operation in flight, latency down-counter running
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int PRIO_FIXED = 0,
    parameter int ALU_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,

    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result
);

    // Counter is loaded with ALU_LAT at acceptance; the response edge is the
    // one that sees it at zero, i.e. ALU_LAT + 1 edges after acceptance.
    localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rsp_kind_e         kind_q, kind_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic              rsp0_err_q, rsp0_err_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
    logic              rsp1_err_q, rsp1_err_d;

    logic [1:0]        gnt;
    logic              last_grant;
    logic              accept;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    rsp_kind_e         sel_kind;
    logic [DATA_W-1:0] fin_data;
    logic              fin_err;

    // The arbiter only records a grant at acceptance, so while in EXEC its
    // last_grant is the id of the port that owns the in-flight operation.
    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({req1_valid, req0_valid}),
        .fixed      (PRIO_FIXED != 0),
        .update     (accept),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    assign req0_ready = (state_q == ST_IDLE) && gnt[0];
    assign req1_ready = (state_q == ST_IDLE) && gnt[1];
    assign accept     = (state_q == ST_IDLE) && (|gnt);

    assign sel_op   = gnt[1] ? req1_op : req0_op;
    assign sel_a    = gnt[1] ? req1_a  : req0_a;
    assign sel_b    = gnt[1] ? req1_b  : req0_b;
    assign sel_kind = classify_op(sel_op, sel_a, sel_b);

    always_comb begin
        fin_data = alu_result;
        fin_err  = 1'b0;
        case (kind_q)
            RSP_ALU:     begin fin_data = alu_result;  fin_err = 1'b0; end
            RSP_ALU_ERR: begin fin_data = alu_result;  fin_err = 1'b1; end
            RSP_DIV0:    begin fin_data = '1;          fin_err = 1'b1; end
            RSP_ILLEGAL: begin fin_data = '0;          fin_err = 1'b1; end
            default:     begin fin_data = alu_result;  fin_err = 1'b0; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kind_d       = kind_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp0_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_valid_d = 1'b0;
        rsp1_data_d  = rsp1_data_q;
        rsp1_err_d   = rsp1_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    kind_d  = sel_kind;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_EXEC;
                    // Divide-by-zero and illegal opcodes never reach the ALU.
                    if ((sel_kind == RSP_ALU) || (sel_kind == RSP_ALU_ERR)) begin
                        alu_op_d = sel_op;
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    if (last_grant) begin
                        rsp1_valid_d = 1'b1;
                        rsp1_data_d  = fin_data;
                        rsp1_err_d   = fin_err;
                    end else begin
                        rsp0_valid_d = 1'b1;
                        rsp0_data_d  = fin_data;
                        rsp0_err_d   = fin_err;
                    end
                    alu_op_d = OP_PASS;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            kind_q       <= RSP_ALU;
            alu_op_q     <= OP_PASS;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kind_q       <= kind_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance share the request inputs, each with its own registered ALU model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;

    logic        r_req0_ready, r_req1_ready, r_rsp0_valid, r_rsp1_valid, r_rsp0_err, r_rsp1_err;
    logic [15:0] r_rsp0_data, r_rsp1_data, r_alu_a, r_alu_b, r_alu_result;
    logic [2:0]  r_alu_op;

    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp0_err, f_rsp1_err;
    logic [15:0] f_rsp0_data, f_rsp1_data, f_alu_a, f_alu_b, f_alu_result;
    logic [2:0]  f_alu_op;

    int n_chk  = 0;
    int n_pass = 0;

    alu_arbiter #(.PRIO_FIXED(0), .ALU_LAT(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(r_rsp0_valid), .rsp0_data(r_rsp0_data), .rsp0_err(r_rsp0_err),
        .rsp1_valid(r_rsp1_valid), .rsp1_data(r_rsp1_data), .rsp1_err(r_rsp1_err),
        .alu_a(r_alu_a), .alu_b(r_alu_b), .alu_op(r_alu_op), .alu_result(r_alu_result)
    );

    alu_arbiter #(.PRIO_FIXED(1), .ALU_LAT(1)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(f_rsp0_valid), .rsp0_data(f_rsp0_data), .rsp0_err(f_rsp0_err),
        .rsp1_valid(f_rsp1_valid), .rsp1_data(f_rsp1_data), .rsp1_err(f_rsp1_err),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op), .alu_result(f_alu_result)
    );

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return p[15:0];
            3'b011:  return (b == 16'd0) ? 16'd0 : a / b;
            3'b111:  return b;
            default: return 16'd0;
        endcase
    endfunction

    // Registered ALU models, one edge of latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_result <= 16'd0;
            f_alu_result <= 16'd0;
        end else begin
            r_alu_result <= alu_f(r_alu_op, r_alu_a, r_alu_b);
            f_alu_result <= alu_f(f_alu_op, f_alu_a, f_alu_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one operation on the round-robin instance and follow it through
    // acceptance (E0), E0+1, the response edge E0+2 and the edge after.
    task automatic run_op(input bit port, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] exp_alu_op,
                          input logic [15:0] exp_data, input logic exp_err, input string tag);
        bit          got;
        logic [15:0] other_data;
        if (port) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if ((port ? r_req1_ready : r_req0_ready) === 1'b1) got = 1'b1;
            else begin @(negedge clk); #1; end
        end
        chk({tag, "_ready"}, 32'(got), 32'd1);
        chk({tag, "_op_before"}, 32'(r_alu_op), 32'(3'b111));
        other_data = port ? r_rsp0_data : r_rsp1_data;

        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk({tag, "_op_e0"}, 32'(r_alu_op), 32'(exp_alu_op));
        chk({tag, "_ready_exec"}, 32'(port ? r_req1_ready : r_req0_ready), 32'd0);

        @(negedge clk);
        chk({tag, "_op_e1"}, 32'(r_alu_op), 32'(exp_alu_op));
        chk({tag, "_vld_e1"}, 32'(port ? r_rsp1_valid : r_rsp0_valid), 32'd0);

        @(negedge clk);
        chk({tag, "_vld_e2"}, 32'(port ? r_rsp1_valid : r_rsp0_valid), 32'd1);
        chk({tag, "_data"},   32'(port ? r_rsp1_data  : r_rsp0_data),  32'(exp_data));
        chk({tag, "_err"},    32'(port ? r_rsp1_err   : r_rsp0_err),   32'(exp_err));
        chk({tag, "_op_after"}, 32'(r_alu_op), 32'(3'b111));
        chk({tag, "_other_vld"},  32'(port ? r_rsp0_valid : r_rsp1_valid), 32'd0);
        chk({tag, "_other_data"}, 32'(port ? r_rsp0_data  : r_rsp1_data),  32'(other_data));

        @(negedge clk);
        chk({tag, "_vld_e3"},  32'(port ? r_rsp1_valid : r_rsp0_valid), 32'd0);
        chk({tag, "_data_hold"}, 32'(port ? r_rsp1_data : r_rsp0_data), 32'(exp_data));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 3'b000; req0_a = 16'd0; req0_b = 16'd0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = 16'd0; req1_b = 16'd0;
        repeat (2) @(negedge clk);

        chk("rst_alu_op",  32'(r_alu_op), 32'(3'b111));
        chk("rst_alu_a",   32'(r_alu_a), 32'd0);
        chk("rst_alu_b",   32'(r_alu_b), 32'd0);
        chk("rst_rsp0_v",  32'(r_rsp0_valid), 32'd0);
        chk("rst_rsp1_d",  32'(r_rsp1_data), 32'd0);
        chk("rst_rsp1_e",  32'(r_rsp1_err), 32'd0);

        rst_n = 1'b1;
        run_op(1'b0, 3'b000, 16'd3,      16'd5,   3'b000, 16'd8,      1'b0, "add");
        run_op(1'b0, 3'b101, 16'd1,      16'd2,   3'b111, 16'd0,      1'b1, "illegal");
        run_op(1'b0, 3'b000, 16'hFFFF,   16'd2,   3'b000, 16'h0001,   1'b0, "add_wrap");
        run_op(1'b0, 3'b001, 16'd0,      16'd1,   3'b001, 16'hFFFF,   1'b0, "sub_wrap");
        run_op(1'b0, 3'b010, 16'h0102,   16'd2,   3'b010, 16'h0204,   1'b1, "mul_ovf");
        run_op(1'b0, 3'b010, 16'd255,    16'd255, 3'b010, 16'hFE01,   1'b0, "mul_8x8");
        run_op(1'b1, 3'b011, 16'd100,    16'd7,   3'b011, 16'd14,     1'b0, "div");
        run_op(1'b1, 3'b011, 16'd100,    16'd0,   3'b111, 16'hFFFF,   1'b1, "div0");

        // Both ports valid every cycle: port 0 first (port 1 was granted last).
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'd10; req0_b = 16'd3;
        req1_valid = 1'b1; req1_op = 3'b010; req1_a = 16'd6;  req1_b = 16'd7;
        #1;
        for (int c = 0; c < 13; c++) begin
            chk("rr_rdy0",   32'(r_req0_ready), 32'(c % 6 == 0));
            chk("rr_rdy1",   32'(r_req1_ready), 32'(c % 6 == 3));
            chk("rr_rsp0_v", 32'(r_rsp0_valid), 32'(c % 6 == 3));
            chk("rr_rsp1_v", 32'(r_rsp1_valid), 32'((c % 6 == 0) && (c > 0)));
            if (c % 6 == 3) chk("rr_rsp0_d", 32'(r_rsp0_data), 32'd7);
            if ((c % 6 == 0) && (c > 0)) chk("rr_rsp1_d", 32'(r_rsp1_data), 32'd42);
            if (c == 12) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);

        // A request raised only during EXEC and dropped again has no effect.
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'd1; req0_b = 16'd1;
        #1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 16'd9; req1_b = 16'd9;
        #1;
        @(negedge clk);
        req1_valid = 1'b0;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (r_rsp0_valid) n0++;
            if (r_rsp1_valid) n1++;
            @(negedge clk);
        end
        chk("drop_rsp0_cnt", 32'(n0), 32'd1);
        chk("drop_rsp0_d",   32'(r_rsp0_data), 32'd2);
        chk("drop_rsp1_cnt", 32'(n1), 32'd0);
        chk("drop_rsp1_d",   32'(r_rsp1_data), 32'd42);

        // Fixed priority instance: port 0 takes every slot, port 1 waits.
        repeat (4) @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'd10; req0_b = 16'd3;
        req1_valid = 1'b1; req1_op = 3'b010; req1_a = 16'd6;  req1_b = 16'd7;
        #1;
        for (int c = 0; c < 13; c++) begin
            chk("fx_rdy0",   32'(f_req0_ready), 32'(c % 3 == 0));
            chk("fx_rdy1",   32'(f_req1_ready), 32'd0);
            chk("fx_rsp0_v", 32'(f_rsp0_valid), 32'((c % 3 == 0) && (c > 0)));
            chk("fx_rsp1_v", 32'(f_rsp1_valid), 32'd0);
            if ((c % 3 == 0) && (c > 0)) chk("fx_rsp0_d", 32'(f_rsp0_data), 32'd7);
            if (c == 12) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk); #1;
        end
        repeat (4) @(negedge clk);

        // Reset one cycle after acceptance, while the operation is in flight.
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'd1; req0_b = 16'd2;
        #1;
        chk("rst_pre_rdy", 32'(r_req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("rst_exec_op", 32'(r_alu_op), 32'(3'b000));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_op",    32'(r_alu_op), 32'(3'b111));
        chk("rst_mid_a",     32'(r_alu_a), 32'd0);
        chk("rst_mid_b",     32'(r_alu_b), 32'd0);
        chk("rst_mid_rsp0v", 32'(r_rsp0_valid), 32'd0);
        chk("rst_mid_rsp0d", 32'(r_rsp0_data), 32'd0);
        chk("rst_mid_rsp1d", 32'(r_rsp1_data), 32'd0);
        chk("rst_mid_rsp0e", 32'(r_rsp0_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (r_rsp0_valid || r_rsp1_valid) n0++;
        end
        chk("rst_no_rsp", 32'(n0), 32'd0);

        // last_grant restarts at 1, so port 0 wins the first tie.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_tie_rdy0", 32'(r_req0_ready), 32'd1);
        chk("rst_tie_rdy1", 32'(r_req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
